// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg
//   Shared types and defaults for the multi-channel clock divider.
//   CLKDIV_W            default divisor/counter width
//   CLKDIV_DEFAULT_DIV  divisor every channel runs at out of reset (half-period)
//   div_t               divisor type at the default width
//   ch_mode_t           channel run state: stopped (divisor 0) or running
package clock_divider_pkg;

    localparam int unsigned CLKDIV_W           = 20;
    localparam int unsigned CLKDIV_DEFAULT_DIV = 32'd1 << 19;

    typedef logic [CLKDIV_W-1:0] div_t;

    typedef enum logic {
        CH_STOP = 1'b0,
        CH_RUN  = 1'b1
    } ch_mode_t;

endpackage

// File: rtl/clock_divider_ch.sv
// clock_divider_ch
//   One divider channel: half-period counter, active divisor, shadow divisor
//   and the pending flag that holds a new divisor until the terminal count.
// Ports
//   osc_clk     in   oscillator clock, all logic on posedge
//   n_reset     in   synchronous active-low reset
//   align       in   restart the channel phase (slow_clock low, count 0)
//   wr_en       in   accepted config transfer for this channel
//   wr_div      in   divisor written into the shadow on wr_en
//   slow_clock  out  divided clock, toggles at every terminal count
//   tick        out  one-cycle strobe coincident with each slow_clock edge
//   pending     out  shadow holds a divisor not yet applied
//   mode        out  channel run state (stopped / running)
module clock_divider_ch
    import clock_divider_pkg::*;
#(
    parameter int unsigned     W           = CLKDIV_W,
    parameter logic [W-1:0]    DEFAULT_DIV = W'(CLKDIV_DEFAULT_DIV)
) (
    input  logic         osc_clk,
    input  logic         n_reset,
    input  logic         align,
    input  logic         wr_en,
    input  logic [W-1:0] wr_div,
    output logic         slow_clock,
    output logic         tick,
    output logic         pending,
    output ch_mode_t     mode
);

    logic [W-1:0] count;
    logic [W-1:0] act_div;
    logic [W-1:0] shadow;
    logic         terminal;
    logic         apply_now;

    // Divisor 0 is handled as a stopped channel, so act_div-1 is only
    // evaluated when act_div >= 1 and can never underflow.
    always_comb begin
        mode      = (act_div == '0) ? CH_STOP : CH_RUN;
        terminal  = (mode == CH_RUN) && (count == act_div - W'(1));
        // A stopped channel has no terminal count to wait for, so its
        // shadow is taken on the first edge after acceptance.
        apply_now = pending && (align || (mode == CH_STOP) || terminal);
    end

    always_ff @(posedge osc_clk) begin
        if (!n_reset) begin
            count      <= '0;
            act_div    <= DEFAULT_DIV;
            shadow     <= '0;
            pending    <= 1'b0;
            tick       <= 1'b0;
            slow_clock <= 1'b0;
        end else begin
            if (align) begin
                count      <= '0;
                tick       <= 1'b0;
                slow_clock <= 1'b0;
            end else if (mode == CH_STOP) begin
                count <= '0;
                tick  <= 1'b0;
            end else if (terminal) begin
                count      <= '0;
                tick       <= 1'b1;
                slow_clock <= ~slow_clock;
            end else begin
                count <= count + W'(1);
                tick  <= 1'b0;
            end

            if (apply_now) begin
                act_div <= shadow;
                pending <= 1'b0;
            end
            // wr_en is only raised while pending is low, so a transfer never
            // races with an apply; a transfer on a terminal edge stays
            // pending until the following terminal count.
            if (wr_en) begin
                shadow  <= wr_div;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider.sv
// clock_divider
//   N_CH independent programmable slow clocks and tick strobes from osc_clk.
//   Divisors are loaded at run time through a valid/ready config port and
//   take effect glitch-free at each channel's terminal count.
// Build option
//   CLKDIV_ALIGN_EN  adds the align input (restart all channel phases)
// Ports
//   osc_clk     in   oscillator clock
//   n_reset     in   synchronous active-low reset
//   cfg_valid   in   config request
//   cfg_ready   out  config can be accepted (target channel not pending)
//   cfg_ch      in   target channel
//   cfg_div     in   new half-period divisor, 0 stops the channel
//   slow_clock  out  per-channel divided clock, period 2*div
//   tick        out  per-channel strobe on each slow_clock edge
//   pending     out  per-channel shadow divisor waiting for terminal count
//   align       in   (CLKDIV_ALIGN_EN only) realign all channels
//
// Config handshake: a transfer happens on a posedge where cfg_valid and
// cfg_ready are both high. cfg_valid may be held high; while the addressed
// channel is pending cfg_ready stays low and the request simply waits.
// A channel index beyond N_CH is always ready and the transfer is dropped.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned W           = CLKDIV_W,
    parameter int unsigned DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
    localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            osc_clk,
    input  logic            n_reset,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [W-1:0]    cfg_div,
    output logic [N_CH-1:0] slow_clock,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] pending
`ifdef CLKDIV_ALIGN_EN
    ,
    input  logic            align
`endif
);

    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

    logic            align_int;
    logic [N_CH-1:0] wr_en;
    ch_mode_t        ch_mode [N_CH];

`ifdef CLKDIV_ALIGN_EN
    assign align_int = align;
`else
    assign align_int = 1'b0;
`endif

    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_en[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clock_divider_ch #(
            .W           (W),
            .DEFAULT_DIV (DEF_DIV)
        ) u_ch (
            .osc_clk    (osc_clk),
            .n_reset    (n_reset),
            .align      (align_int),
            .wr_en      (wr_en[g]),
            .wr_div     (cfg_div),
            .slow_clock (slow_clock[g]),
            .tick       (tick[g]),
            .pending    (pending[g]),
            .mode       (ch_mode[g])
        );
    end

endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider
//   Directed bench for clock_divider with W=8, N_CH=4, DEFAULT_DIV=4.
//   Expected tick cycles (posedge count since time 0) are queued per channel
//   when stimulus is issued; a negedge monitor pops one entry per observed tick.
module tb_clock_divider;

    localparam int N_CH = 4;
    localparam int W    = 8;

    logic            osc_clk   = 1'b0;
    logic            n_reset   = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [1:0]      cfg_ch    = '0;
    logic [W-1:0]    cfg_div   = '0;
    logic            cfg_ready;
    logic [N_CH-1:0] slow_clock;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] pending;
`ifdef CLKDIV_ALIGN_EN
    logic            align = 1'b0;
`endif

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q [N_CH][$];

    clock_divider #(
        .N_CH        (N_CH),
        .W           (W),
        .DEFAULT_DIV (4)
    ) dut (
        .osc_clk    (osc_clk),
        .n_reset    (n_reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .slow_clock (slow_clock),
        .tick       (tick),
        .pending    (pending)
`ifdef CLKDIV_ALIGN_EN
        ,
        .align      (align)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 osc_clk = ~osc_clk;

    always @(posedge osc_clk) cyc <= cyc + 1;

    initial begin
        #20000;
        $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge osc_clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic push_ticks(input int ch, input int first, input int last, input int step);
        for (int t = first; t <= last; t += step) exp_q[ch].push_back(16'(t));
    endtask

    // Issue at a negedge, accepted on the next posedge, released at the next negedge.
    task automatic cfg_write(input logic [1:0] ch, input logic [W-1:0] div);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        @(negedge osc_clk);
        cfg_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge osc_clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (tick[c]) begin
                n_checks++;
                if (exp_q[c].size() == 0) begin
                    $display("FAIL tick_ch%0d: got tick at cycle %0d expected none", c, cyc);
                end else begin
                    logic [15:0] e;
                    e = exp_q[c].pop_front();
                    if (e == 16'(cyc)) n_pass++;
                    else $display("FAIL tick_ch%0d: got tick at cycle %0d expected cycle %0d", c, cyc, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        wait_cyc(2);
        #1;
        check("rst_slow", int'(slow_clock), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_ready", int'(cfg_ready), 1);

        // Release: all channels at div 4, first tick 4 cycles later
        wait_cyc(3);
        n_reset = 1'b1;
        push_ticks(0, 7, 35, 4);
        push_ticks(1, 7, 15, 4);
        push_ticks(2, 7, 19, 4);
        push_ticks(3, 7, 47, 4);

        wait_cyc(8);
        check("slow_after_first_tick", int'(slow_clock), 15);
        wait_cyc(12);
        check("slow_after_second_tick", int'(slow_clock), 0);

        // ch1 div=2 mid-period; held request with a different divisor is refused
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd2;
        push_ticks(1, 17, 49, 2);
        wait_cyc(13);
        cfg_div = 8'd7;
        #1;
        check("ch1_pending_set", int'(pending[1]), 1);
        check("ch1_ready_low", int'(cfg_ready), 0);
        wait_cyc(14);
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        #1;
        check("ch0_ready_high", int'(cfg_ready), 1);
        cfg_ch = 2'd1;
        #1;
        check("ch1_ready_still_low", int'(cfg_ready), 0);
        wait_cyc(15);
        #1;
        check("ch1_pending_clear", int'(pending[1]), 0);
        wait_cyc(18);
        check("ch1_slow_fast", int'(slow_clock[1]), 0);

        // ch2 div=0: freezes with slow_clock high after tick at 23
        wait_cyc(20);
        push_ticks(2, 23, 23, 1);
        cfg_write(2'd2, 8'd0);
        wait_cyc(30);
        check("ch2_slow_held", int'(slow_clock[2]), 1);
        check("ch2_pending_clear", int'(pending[2]), 0);
        // ch2 div=1 from stopped: applied on edge 32, tick every cycle from 33
        push_ticks(2, 33, 49, 1);
        cfg_write(2'd2, 8'd1);
        wait_cyc(33);
        check("ch2_slow_toggle_a", int'(slow_clock[2]), 0);
        wait_cyc(34);
        check("ch2_slow_toggle_b", int'(slow_clock[2]), 1);

        // ch0 div=3 accepted on its tick edge 35: applied at 39, then every 3
        push_ticks(0, 39, 48, 3);
        cfg_write(2'd0, 8'd3);
        wait_cyc(38);
        check("ch0_pending_held", int'(pending[0]), 1);
        wait_cyc(39);
        check("ch0_pending_applied", int'(pending[0]), 0);

        // ch3 pending and mid-count, then a one-cycle reset on edge 50
        wait_cyc(48);
        cfg_write(2'd3, 8'd5);
        check("ch3_pending_set", int'(pending[3]), 1);
        n_reset = 1'b0;
        wait_cyc(50);
        n_reset = 1'b1;
        #1;
        check("rst2_slow", int'(slow_clock), 0);
        check("rst2_tick", int'(tick), 0);
        check("rst2_pending", int'(pending), 0);
        for (int c = 0; c < N_CH; c++) push_ticks(c, 54, 70, 4);

        // ch1 div=5 pending at 73; edge 74 is either align or ch1's terminal count
        wait_cyc(72);
`ifdef CLKDIV_ALIGN_EN
        push_ticks(0, 78, 86, 4);
        push_ticks(1, 79, 84, 5);
        push_ticks(2, 78, 86, 4);
        push_ticks(3, 78, 86, 4);
`else
        push_ticks(0, 74, 86, 4);
        push_ticks(1, 74, 84, 5);
        push_ticks(2, 74, 86, 4);
        push_ticks(3, 74, 86, 4);
`endif
        cfg_write(2'd1, 8'd5);
        check("ch1_pending_div5", int'(pending[1]), 1);
`ifdef CLKDIV_ALIGN_EN
        align = 1'b1;
`endif
        wait_cyc(74);
`ifdef CLKDIV_ALIGN_EN
        align = 1'b0;
`endif
        check("slow_at_74", int'(slow_clock), 0);
        check("ch1_pending_div5_clear", int'(pending[1]), 0);

        wait_cyc(87);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            check($sformatf("missing_ticks_ch%0d", c), exp_q[c].size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
